// File: rtl/i2c_slave_controller.sv
// i2c_slave_controller: I2C target answering one 7-bit address (SLAVE_ADDR).
// Detects START/STOP/repeated START, receives write bytes on rx_data_out and
// shifts read bytes from tx_data_in onto SDA. Bus pins are open-drain (0 or Z).
// Optional feature macro: I2C_SLAVE_CLK_STRETCH_EN adds tx_valid_in and holds
// SCL low at a byte load until transmit data is valid.
module i2c_slave_controller #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       i2c_clock_in,
   input  logic       i2c_reset_in,
   input  logic [7:0] tx_data_in,
`ifdef I2C_SLAVE_CLK_STRETCH_EN
   input  logic       tx_valid_in,
`endif
   output logic       tx_ready_out,
   output logic [7:0] rx_data_out,
   output logic       rx_valid_out,
   output logic       rw_out,
   output logic       busy_out,
   inout  wire        i2c_sda_inout,
   inout  wire        i2c_scl_inout
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
   } state_t;

   // All protocol state in one record so the next-state process can start
   // from a copy of the current state and only touch what changes.
   typedef struct packed {
      state_t     state;
      logic [2:0] bit_cnt;
      logic [7:0] shift;
      logic       ack_phase;   // first ACK fall (drive) seen, waiting for the second
      logic       sda_low;
      logic       scl_low;
      logic       tx_wait;     // byte load pending on tx_valid while SCL is stretched
      logic [7:0] rx_data;
      logic       rx_valid;
      logic       tx_ready;
      logic       rw;
      logic       busy;
   } regs_t;

   regs_t      r, n;
   logic [1:0] scl_sync, sda_sync;
   logic       scl_dly, sda_dly;
   logic       scl_rise, scl_fall, start_det, stop_det, sda_smp;
   logic [7:0] shifted;
   logic       tx_valid;
   logic       tx_load_req;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
   assign tx_valid = tx_valid_in;
`else
   assign tx_valid = 1'b1;
`endif

   // Two-flop synchronisers followed by registered edge and bus-condition detectors
   always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      if (i2c_reset_in) begin
         scl_sync  <= 2'b11;
         sda_sync  <= 2'b11;
         scl_dly   <= 1'b1;
         sda_dly   <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         sda_smp   <= 1'b1;
      end else begin
         scl_sync  <= {scl_sync[0], i2c_scl_inout};
         sda_sync  <= {sda_sync[0], i2c_sda_inout};
         scl_dly   <= scl_sync[1];
         sda_dly   <= sda_sync[1];
         scl_rise  <= scl_sync[1] & ~scl_dly;
         scl_fall  <= ~scl_sync[1] & scl_dly;
         start_det <= scl_sync[1] & scl_dly & sda_dly & ~sda_sync[1];
         stop_det  <= scl_sync[1] & scl_dly & ~sda_dly & sda_sync[1];
         sda_smp   <= sda_sync[1];
      end
   end

   assign shifted = {r.shift[6:0], sda_smp};

   // Protocol state register; reset releases both pins immediately
   always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
      if (i2c_reset_in) r <= '0;
      else              r <= n;
   end

   // Next-state logic: bus conditions first, then pending load, then per-state bit handling
   always_comb begin
      // NOTE: defaults first so no path leaves a field unassigned (no latches).
      n           = r;
      n.rx_valid  = 1'b0;
      n.tx_ready  = 1'b0;
      tx_load_req = 1'b0;
      if (stop_det) begin
         n.state     = IDLE;
         n.sda_low   = 1'b0;
         n.scl_low   = 1'b0;
         n.tx_wait   = 1'b0;
         n.ack_phase = 1'b0;
         n.busy      = 1'b0;
      end else if (start_det) begin
         n.state     = ADDR;
         n.bit_cnt   = 3'd0;
         n.shift     = 8'h00;
         n.sda_low   = 1'b0;
         n.scl_low   = 1'b0;
         n.tx_wait   = 1'b0;
         n.ack_phase = 1'b0;
         n.busy      = 1'b0;
      end else if (r.tx_wait) begin
         // SCL stays low this cycle; it is released once tx_wait has cleared.
         n.tx_wait   = 1'b0;
         tx_load_req = 1'b1;
      end else begin
         n.scl_low = 1'b0;
         case (r.state)
            ADDR: if (scl_rise) begin
               n.shift   = shifted;
               n.bit_cnt = r.bit_cnt + 3'd1;
               if (r.bit_cnt == 3'd7) begin
                  if (shifted[7:1] == SLAVE_ADDR) begin
                     n.rw        = shifted[0];
                     n.state     = ADDR_ACK;
                     n.ack_phase = 1'b0;
                  end else begin
                     n.state = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: if (scl_fall) begin
               if (!r.ack_phase) begin
                  n.sda_low   = 1'b1;
                  n.busy      = 1'b1;
                  n.ack_phase = 1'b1;
               end else begin
                  n.ack_phase = 1'b0;
                  if (r.rw) begin
                     tx_load_req = 1'b1;
                  end else begin
                     n.sda_low = 1'b0;
                     n.state   = RX_BYTE;
                     n.bit_cnt = 3'd0;
                  end
               end
            end
            RX_BYTE: if (scl_rise) begin
               n.shift   = shifted;
               n.bit_cnt = r.bit_cnt + 3'd1;
               if (r.bit_cnt == 3'd7) begin
                  n.rx_data   = shifted;
                  n.rx_valid  = 1'b1;
                  n.state     = RX_ACK;
                  n.ack_phase = 1'b0;
               end
            end
            RX_ACK: if (scl_fall) begin
               if (!r.ack_phase) begin
                  n.sda_low   = 1'b1;
                  n.ack_phase = 1'b1;
               end else begin
                  n.sda_low   = 1'b0;
                  n.ack_phase = 1'b0;
                  n.state     = RX_BYTE;
                  n.bit_cnt   = 3'd0;
               end
            end
            TX_BYTE: if (scl_fall) begin
               if (r.bit_cnt == 3'd7) begin
                  n.sda_low = 1'b0;
                  n.state   = TX_ACK;
                  n.bit_cnt = 3'd0;
               end else begin
                  n.shift   = {r.shift[6:0], 1'b0};
                  n.sda_low = ~r.shift[6];
                  n.bit_cnt = r.bit_cnt + 3'd1;
               end
            end
            TX_ACK: begin
               if (scl_rise && sda_smp) n.state = WAIT_STOP;
               else if (scl_fall)       tx_load_req = 1'b1;
            end
            default: ;
         endcase
      end

      // Shared byte load: either take tx_data_in now or stretch SCL until it is valid.
      if (tx_load_req) begin
         n.state   = TX_BYTE;
         n.bit_cnt = 3'd0;
         if (tx_valid) begin
            n.shift    = tx_data_in;
            n.sda_low  = ~tx_data_in[7];
            n.tx_ready = 1'b1;
         end else begin
            n.tx_wait = 1'b1;
            n.scl_low = 1'b1;
            n.sda_low = 1'b0;
         end
      end
   end

   assign i2c_sda_inout = r.sda_low ? 1'b0 : 1'bz;
   assign i2c_scl_inout = r.scl_low ? 1'b0 : 1'bz;
   assign tx_ready_out  = r.tx_ready;
   assign rx_data_out   = r.rx_data;
   assign rx_valid_out  = r.rx_valid;
   assign rw_out        = r.rw;
   assign busy_out      = r.busy;

endmodule
